key_loader64: RTL



---
 rtl/key_loader64.sv | 125 ++++++++++++
 1 files changed

// File: rtl/key_loader64.sv
// rtl/key_loader64.sv - serial unlock-key loader with XOR check byte and lockout.
// Drives a stable key bus into the locked adder; repeated bad frames latch a lockout.
module key_loader64 #(
  parameter int KEY_W     = 64,
  parameter int CHK_W     = 8,
  parameter int MAX_FAILS = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_start_i,
  input  logic             key_sdi_i,
  input  logic             key_svalid_i,
  output logic             key_sready_o,
  input  logic             zeroize_i,
  output logic [KEY_W-1:0] key_o,
  output logic             key_valid_o,
  output logic             key_err_o,
  output logic             lockout_o,
  output logic             busy_o
);

  localparam int FRAME_W = KEY_W + CHK_W;
  localparam int CNT_W   = $clog2(FRAME_W + 1);

  typedef enum logic [2:0] {IDLE, SHIFT, CHECK, ARMED, LOCKOUT} state_t;

  state_t               state, state_d;
  logic [CNT_W-1:0]     cnt, cnt_d;
  logic [3:0]           fails, fails_d;
  logic [4:0]           fails_inc;
  logic [FRAME_W-1:0]   shreg, shreg_d;
  logic [KEY_W-1:0]     key_d;
  logic                 valid_d;
  logic                 err_d;
  logic [CHK_W-1:0]     sum;

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    fails_d   = fails;
    shreg_d   = shreg;
    key_d     = key_o;
    valid_d   = key_valid_o;
    err_d     = 1'b0;
    fails_inc = {1'b0, fails} + 5'd1;
    sum       = '0;
    for (int i = 0; i < KEY_W / 8; i++) begin
      sum = sum ^ shreg[CHK_W + 8*i +: 8];
    end

    case (state)
      IDLE, ARMED: begin
        if (load_start_i) begin
          // entering SHIFT drops any previously accepted key
          state_d = SHIFT;
          cnt_d   = '0;
          shreg_d = '0;
          key_d   = '0;
          valid_d = 1'b0;
        end
      end
      SHIFT: begin
        if (key_svalid_i && key_sready_o) begin
          shreg_d = {shreg[FRAME_W-2:0], key_sdi_i};
          cnt_d   = cnt + 1'b1;
          if (cnt == CNT_W'(FRAME_W - 1)) state_d = CHECK;
        end
      end
      CHECK: begin
        if (sum == shreg[CHK_W-1:0]) begin
          key_d   = shreg[FRAME_W-1:CHK_W];
          valid_d = 1'b1;
          fails_d = '0;
          state_d = ARMED;
        end else begin
          err_d   = 1'b1;
          fails_d = fails_inc[3:0];
          state_d = (fails_inc >= 5'(MAX_FAILS)) ? LOCKOUT : IDLE;
        end
      end
      LOCKOUT: begin
        key_d   = '0;
        valid_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    // zeroize wins over load and over a passing check; fail count survives it
    if (zeroize_i && state != LOCKOUT) begin
      state_d = IDLE;
      cnt_d   = '0;
      key_d   = '0;
      valid_d = 1'b0;
      fails_d = fails;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= IDLE;
      cnt          <= '0;
      fails        <= '0;
      shreg        <= '0;
      key_o        <= '0;
      key_valid_o  <= 1'b0;
      key_err_o    <= 1'b0;
      lockout_o    <= 1'b0;
      key_sready_o <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      fails        <= fails_d;
      shreg        <= shreg_d;
      key_o        <= key_d;
      key_valid_o  <= valid_d;
      key_err_o    <= err_d;
      lockout_o    <= (state_d == LOCKOUT);
      key_sready_o <= (state_d == SHIFT);
      busy_o       <= (state_d == SHIFT) || (state_d == CHECK);
    end
  end

endmodule
